// File: rtl/d8_mem_pkg.sv
// Shared defaults and arbiter state encoding for the CPU/VGA shared-RAM arbiter.
package d8_mem_pkg;

    localparam int unsigned AW_DEF        = 12;
    localparam int unsigned DW_DEF        = 8;
    localparam int unsigned VGA_BURST_DEF = 4;

    // Owner of the current memory cycle
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_VGA  = 2'd1,
        ST_CPU  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arb_fair.sv
// Grant decision plus VGA streak counter: VGA wins ties until it has taken
// VGA_BURST consecutive cycles while the CPU waits, then the CPU gets one.
module mem_arb_fair
    import d8_mem_pkg::*;
#(
    parameter int unsigned VGA_BURST = VGA_BURST_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_cpu_req,
    input  logic       i_vga_req,
    output logic       o_cpu_gnt_c,
    output logic       o_vga_gnt_c,
    output arb_state_e o_state
);

    localparam int unsigned SW = $clog2(VGA_BURST + 1);

    arb_state_e    r_state;
    arb_state_e    w_next_state;
    logic [SW-1:0] r_streak;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Owner of this cycle is decided combinationally; grants follow directly
    always_comb begin
        w_next_state = ST_IDLE;
        o_cpu_gnt_c  = 1'b0;
        o_vga_gnt_c  = 1'b0;
        if (i_rst_n) begin
            if (i_cpu_req && i_vga_req) begin
                w_next_state = (r_streak >= SW'(VGA_BURST)) ? ST_CPU : ST_VGA;
            end else if (i_cpu_req) begin
                w_next_state = ST_CPU;
            end else if (i_vga_req) begin
                w_next_state = ST_VGA;
            end
        end
        o_cpu_gnt_c = (w_next_state == ST_CPU);
        o_vga_gnt_c = (w_next_state == ST_VGA);
    end

    // Counts VGA grants taken while the CPU is waiting; saturates at VGA_BURST
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_streak <= '0;
        end else if (!i_cpu_req || o_cpu_gnt_c) begin
            r_streak <= '0;
        end else if (o_vga_gnt_c && (r_streak < SW'(VGA_BURST))) begin
            r_streak <= r_streak + SW'(1);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/mem_arbiter.sv
// Shared single-port RAM arbiter between a read/write CPU port and a read-only
// VGA port: address/data muxing and one-cycle read-valid pipeline.
module mem_arbiter
    import d8_mem_pkg::*;
#(
    parameter int unsigned AW        = AW_DEF,
    parameter int unsigned DW        = DW_DEF,
    parameter int unsigned VGA_BURST = VGA_BURST_DEF
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_a,
    input  logic [DW-1:0] cpu_dw,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_dr,
    input  logic          vga_req,
    input  logic [AW-1:0] vga_a,
    output logic          vga_gnt,
    output logic          vga_rvalid,
    output logic [DW-1:0] vga_dr,
    output logic [AW-1:0] mem_a,
    output logic          mem_we,
    output logic [DW-1:0] mem_dw,
    input  logic [DW-1:0] mem_dr
);

    logic       w_cpu_gnt;
    logic       w_vga_gnt;
    arb_state_e w_state;
    logic       r_cpu_rvalid;
    logic       w_cpu_rvalid;
    logic       w_vga_rvalid;

    mem_arb_fair #(
        .VGA_BURST (VGA_BURST)
    ) u_fair (
        .i_clk       (sys_clk),
        .i_rst_n     (sys_rst),
        .i_cpu_req   (cpu_req),
        .i_vga_req   (vga_req),
        .o_cpu_gnt_c (w_cpu_gnt),
        .o_vga_gnt_c (w_vga_gnt),
        .o_state     (w_state)
    );

    assign cpu_gnt = w_cpu_gnt;
    assign vga_gnt = w_vga_gnt;

    // RAM port driven from whichever requester owns this cycle
    always_comb begin
        mem_a  = '0;
        mem_we = 1'b0;
        mem_dw = '0;
        if (w_cpu_gnt) begin
            mem_a  = cpu_a;
            mem_we = cpu_we;
            mem_dw = cpu_dw;
        end else if (w_vga_gnt) begin
            mem_a  = vga_a;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            r_cpu_rvalid <= 1'b0;
        end else begin
            r_cpu_rvalid <= w_cpu_gnt & ~cpu_we;
        end
    end

    // VGA only reads, so last cycle's owner being VGA is its read-valid
    assign w_vga_rvalid = (w_state == ST_VGA);

    // Reset masks the read side immediately so a pending read never leaks out
    assign w_cpu_rvalid = r_cpu_rvalid & sys_rst;
    assign cpu_rvalid   = w_cpu_rvalid;
    assign vga_rvalid   = w_vga_rvalid & sys_rst;
    assign cpu_dr       = w_cpu_rvalid ? mem_dr : '0;
    assign vga_dr       = vga_rvalid ? mem_dr : '0;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, 12, memory address width.
REQ-002 Parameter DW, 8, memory data width.
REQ-003 Parameter VGA_BURST, 4, max consecutive VGA grants while CPU waits.
REQ-004 sys_clk  in  1  single clock; all logic on posedge.
REQ-005 sys_rst  in  1  reset, synchronous, active-low.
REQ-006 cpu_req  in  1  CPU access request.
REQ-007 cpu_we  in  1  CPU write (1) / read (0).
REQ-008 cpu_a  in  AW  CPU address.
REQ-009 cpu_dw  in  DW  CPU write data.
REQ-010 cpu_gnt  out  1  CPU access issued this cycle.
REQ-011 cpu_rvalid  out  1  cpu_dr valid.
REQ-012 cpu_dr  out  DW  CPU read data.
REQ-013 vga_req  in  1  VGA read request (read-only port).
REQ-014 vga_a  in  AW  VGA address.
REQ-015 vga_gnt  out  1  VGA access issued this cycle.
REQ-016 vga_rvalid  out  1  vga_dr valid.
REQ-017 vga_dr  out  DW  VGA read data.
REQ-018 mem_a  out  AW  shared RAM address.
REQ-019 mem_we  out  1  shared RAM write enable.
REQ-020 mem_dw  out  DW  shared RAM write data.
REQ-021 mem_dr  in  DW  shared RAM read data, valid one cycle after address.

Function
REQ-022 FSM states IDLE, VGA, CPU = owner of current cycle; next state decided combinationally from requests and streak counter, registered each posedge.
REQ-023 Decision: no req -> IDLE; only one req -> that requester; both req and streak < VGA_BURST -> VGA; both req and streak == VGA_BURST -> CPU.
REQ-024 Grant combinational in the decision cycle: xx_gnt = 1, mem_a/mem_we/mem_dw driven from granted port in same cycle; at most one gnt high per cycle.
REQ-025 VGA grant: mem_we = 0, mem_dw = 0.
REQ-026 No grant: mem_a = 0, mem_we = 0, mem_dw = 0.
REQ-027 Requester holds req/a/we/dw stable until it samples gnt = 1; req may drop the cycle after gnt; back-to-back grants to same port allowed every cycle.
REQ-028 Read latency: xx_rvalid registered, high exactly the cycle after a read grant; xx_dr = mem_dr when rvalid, 0 otherwise.
REQ-029 Write grant produces no rvalid.
REQ-030 Streak counter, width clog2(VGA_BURST+1): +1 on VGA grant while cpu_req = 1; cleared on CPU grant or when cpu_req = 0; saturates at VGA_BURST.
REQ-031 CPU worst-case wait with continuous vga_req = VGA_BURST cycles.
REQ-032 vga_req alone never stalled; cpu_req alone never stalled.

Reset
REQ-033 sys_rst = 0 at posedge: state IDLE, streak 0, both rvalid 0.
REQ-034 While sys_rst = 0: both gnt 0, mem_we 0, mem_a 0, mem_dw 0, both dr 0, regardless of requests.
REQ-035 Reset mid-read: pending rvalid dropped; first post-reset cycle arbitrates fresh.

Structure
REQ-036 Package d8_mem_pkg holds AW, DW, VGA_BURST defaults and FSM state encoding.
REQ-037 One sub-module mem_arb_fair: streak counter plus grant decision; mem_arbiter holds muxing and rvalid pipeline.

Verification
REQ-038 CPU write 0xA5 @0x123 alone -> cpu_gnt same cycle, mem_we=1, mem_a=0x123, mem_dw=0xA5, no rvalid.
REQ-039 CPU read 0x123 after that write (RAM model) -> cpu_rvalid next cycle, cpu_dr=0xA5.
REQ-040 vga_req and cpu_req held high 12 cycles -> grants VGA×4, CPU×1, VGA×4, CPU×1, ...; never both gnt.
REQ-041 Both req in same first cycle, streak 0 -> vga_gnt, cpu_gnt 0; CPU granted by cycle 5.
REQ-042 sys_rst low one cycle right after VGA read grant -> vga_rvalid stays 0, all outputs 0, streak 0.
REQ-043 VGA streaming reads 0x000..0x00F, no CPU -> 16 consecutive gnts, rvalid each following cycle, data matches RAM.
